// File: rtl/dff_capture_arbiter.sv
// Round-robin arbiter feeding a one-entry capture register.
// Captures winner data bit, index and timestamp; drained by valid/ready.
module dff_capture_arbiter #(
  parameter int NREQ = 4,
  parameter int TS_W = 32,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_en,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ-1:0] req_data,
  output logic [NREQ-1:0] req_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_data,
  output logic [IDW-1:0]  out_id,
  output logic [TS_W-1:0] out_ts
);

  logic [TS_W-1:0] ts_cnt;
  logic [IDW-1:0]  last_grant;
  logic [IDW-1:0]  win;
  logic [IDW:0]    j_w;
  logic            found;
  logic            can_accept;
  logic            grant;

  assign can_accept = rst_n && cfg_en &&
                      (!out_valid || out_ready);

  // Search upward from last_grant+1, wrapping modulo NREQ.
  always_comb begin
    win   = '0;
    found = 1'b0;
    j_w   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j_w = {1'b0, last_grant} + (IDW+1)'(k);
      if (j_w >= (IDW+1)'(NREQ))
        j_w = j_w - (IDW+1)'(NREQ);
      if (!found && req_valid[j_w[IDW-1:0]]) begin
        found = 1'b1;
        win   = j_w[IDW-1:0];
      end
    end
  end

  assign grant = can_accept && found;

  always_comb begin
    req_ready = '0;
    if (grant)
      req_ready[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt     <= '0;
      last_grant <= IDW'(NREQ-1);
      out_valid  <= 1'b0;
      out_data   <= 1'b0;
      out_id     <= '0;
      out_ts     <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
      if (grant) begin
        out_valid  <= 1'b1;
        out_data   <= req_data[win];
        out_id     <= win;
        out_ts     <= ts_cnt;
        last_grant <= win;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dff_capture_arbiter.sv
// Scoreboard bench for dff_capture_arbiter: reference model pushes
// expected entries, a monitor pops them when the DUT drains.
module tb_dff_capture_arbiter;

  localparam int N  = 4;
  localparam int TW = 4;
  localparam int TM = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_en;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_data;
  logic [N-1:0]  req_ready;
  logic          out_valid;
  logic          out_ready;
  logic          out_data;
  logic [1:0]    out_id;
  logic [TW-1:0] out_ts;

  dff_capture_arbiter #(.NREQ(N), .TS_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .out_ts(out_ts)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic d;
    int   id;
    int   ts;
  } ent_t;

  ent_t q[$];
  int vec = 0;
  int mis = 0;

  int       m_ts = 0;
  int       m_lg = N-1;
  logic     m_v  = 1'b0;
  logic [N-1:0] gmask = '0;
  int       w;
  logic [N-1:0] exp_rdy;
  ent_t     e;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] x);
    vec++;
    if (a !== x) begin
      mis++;
      $display("FAIL %s: got %0h expected %0h @%0t", n, a, x, $time);
    end
  endtask

  // Reference model: priority rotation and occupancy from the rules.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_ts  = 0;
      m_lg  = N-1;
      m_v   = 1'b0;
      gmask = '0;
      q.delete();
    end else begin
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_v});
      exp_rdy = '0;
      w = -1;
      if (cfg_en && (!m_v || out_ready))
        for (int k = 1; k <= N; k++)
          if (w < 0 && req_valid[(m_lg + k) % N])
            w = (m_lg + k) % N;
      if (w >= 0) exp_rdy[w] = 1'b1;
      chk("req_ready", {28'b0, req_ready}, {28'b0, exp_rdy});
      gmask = exp_rdy;
      if (w >= 0) begin
        q.push_back('{req_data[w], w, m_ts});
        m_v  = 1'b1;
        m_lg = w;
      end else if (m_v && out_ready) begin
        m_v = 1'b0;
      end
      m_ts = (m_ts + 1) % TM;
    end
  end

  // Monitor: compare the presented entry, pop on drain.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        chk("queue_nonempty", 32'd0, 32'd1);
      end else begin
        chk("out_data", {31'b0, out_data}, {31'b0, q[0].d});
        chk("out_id", {30'b0, out_id}, q[0].id);
        chk("out_ts", {28'b0, out_ts}, q[0].ts);
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    cyc();
    req_valid = req_valid & ~gmask;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    cfg_en = 1'b1;
    req_valid = 4'b1111;
    req_data = '0;
    out_ready = 1'b1;
    #2;
    chk("rst_req_ready", {28'b0, req_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_ts", {28'b0, out_ts}, 32'd0);
    req_valid = '0;
    cyc();
    cyc();
    rst_n = 1'b1;

    // Single request in the ts_cnt=5 cycle
    repeat (5) cyc();
    req_valid = 4'b0100;
    req_data = 4'b0100;
    #1;
    chk("single_ready", {28'b0, req_ready}, 32'h4);
    cyc();
    req_valid = '0;
    chk("single_id", {30'b0, out_id}, 32'd2);
    chk("single_data", {31'b0, out_data}, 32'd1);
    chk("single_ts", {28'b0, out_ts}, 32'd5);

    // Round robin, crossing the 15->0 timestamp wrap
    req_valid = 4'b1111;
    req_data = 4'($urandom);
    for (int i = 0; i < 12; i++) begin
      cyc();
      chk("rr_id", {30'b0, out_id}, (3 + i) % N);
      chk("rr_ts", {28'b0, out_ts}, (6 + i) % TM);
    end

    // Backpressure with an entry held
    req_valid = 4'b0011;
    out_ready = 1'b0;
    repeat (10) cyc();
    out_ready = 1'b1;
    repeat (3) step();

    // Grants disabled
    cfg_en = 1'b0;
    req_valid = 4'b1111;
    req_data = 4'($urandom);
    repeat (8) cyc();
    cfg_en = 1'b1;
    repeat (5) step();

    // Reset while an entry is held and last grant is 2
    req_valid = 4'b0100;
    step();
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_req_ready", {28'b0, req_ready}, 32'd0);
    req_valid = '0;
    cyc();
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    req_valid = 4'b1111;
    req_data = 4'($urandom);
    out_ready = 1'b1;
    step();
    chk("post_rst_id", {30'b0, out_id}, 32'd0);
    chk("post_rst_ts", {28'b0, out_ts}, 32'd3);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && ($urandom % 3 == 0)) begin
          req_valid[i] = 1'b1;
          req_data[i] = 1'($urandom);
        end
      cfg_en = ($urandom % 8) != 0;
      out_ready = ($urandom % 3) != 0;
      step();
    end

    req_valid = '0;
    cfg_en = 1'b1;
    out_ready = 1'b1;
    repeat (4) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule

// File: doc/dff_capture_arbiter.md
# dff_capture_arbiter

Round-robin arbiter that shares a single registered capture stage among NREQ single-bit requesters. Each grant captures the winner's data bit, its index and a free-running cycle timestamp into a one-entry output register. The register is drained through a valid/ready handshake. The block sits between the per-channel sampling flops and the downstream event logger.

## Interface
- NREQ, default 4: number of requesters; legal range 2..16.
- TS_W, default 32: timestamp counter width.
- IDW, default $clog2(NREQ): width of out_id (derived; not overridden).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_en  in  1  grant enable; when low no new grants are issued, and the timestamp counter keeps running.
- req_valid  in  NREQ  per-requester request; must be held until the matching req_ready.
- req_data  in  NREQ  per-requester data bit; stable while req_valid is high.
- req_ready  out  NREQ  one-hot grant, combinational, at most one bit set.
- out_valid  out  1  capture register holds an entry.
- out_ready  in  1  downstream accepts the entry.
- out_data  out  1  captured data bit.
- out_id  out  IDW  index of the granted requester.
- out_ts  out  TS_W  timestamp counter value in the grant cycle.

## Operation
- **Timestamp counter `ts_cnt`**
  - Resets to 0 and increments by 1 every clk.
  - Wraps from 2^TS_W-1 to 0 with no flag.
- **Accept condition:** `can_accept = cfg_en && (!out_valid || out_ready)`.
- **Arbitration**
  - When can_accept and any req_valid bit is set, the winner is the first set bit searched upward from `(last_grant+1) mod NREQ`, wrapping.
  - req_ready[winner]=1 in the same cycle; all other req_ready bits are 0.
  - When can_accept is low, or no request is present, req_ready is all 0.
- **Grant (req_valid[i] && req_ready[i])**
  - At the next edge: out_data<=req_data[i], out_id<=i, out_ts<=ts_cnt (pre-increment value), out_valid<=1, last_grant<=i.
- **Drain**
  - out_valid && out_ready with no grant in the same cycle: out_valid<=0 at the next edge.
  - A simultaneous drain and grant loads the new entry and leaves out_valid at 1. Sustained throughput is one entry per cycle.
- **Output stability:** while out_valid && !out_ready, out_data, out_id and out_ts hold stable.
- **last_grant** is updated only on a grant. Its reset value is NREQ-1, so requester 0 has first priority after reset.
- **Effective states**
  - EMPTY (out_valid=0): accepts if cfg_en.
  - FULL (out_valid=1): accepts only if out_ready && cfg_en.
- **cfg_en falling while FULL:** the held entry still drains normally.
- **Reset values:** out_valid=0, out_data=0, out_id=0, out_ts=0, last_grant=NREQ-1, ts_cnt=0. req_ready is 0 during reset.
- **Reset mid-operation:** a pending entry is discarded and arbitration restarts at requester 0. Requesters re-present after reset.

## Timing
- Grant to out_valid latency is 1 cycle.
- req_ready depends combinationally on req_valid, out_valid, out_ready and cfg_en. There is no combinational path from req_data to outputs.
- Fairness: a continuously asserted requester is granted within NREQ grants.
- out_ts equals the ts_cnt value sampled in the grant cycle. Consecutive back-to-back grants therefore differ in out_ts by exactly 1.
- Reset assertion clears all registers immediately. Operation resumes on the first clk edge after rst_n rises, and that edge is the first ts_cnt increment.

## Test plan
- **Single request:** reset, cfg_en=1, out_ready=1, req_valid=4'b0100, req_data[2]=1 in the cycle where ts_cnt=5.
  - req_ready=4'b0100 in that cycle.
  - Next cycle: out_valid=1, out_id=2, out_data=1, out_ts=5.
- **Round robin:** req_valid=4'b1111 held, out_ready=1.
  - Grant order is 0,1,2,3,0,…, one grant per cycle.
  - out_ts increments by 1 per entry.
- **Backpressure:** out_ready=0 with an entry held and req_valid=4'b0011.
  - req_ready=0 and the output stays stable for 10 cycles.
  - After out_ready=1: the next winner is granted in the same cycle and out_valid never drops.
- **cfg_en=0:** req_valid=4'b1111 for 8 cycles gives no grants, and ts_cnt still advances by 8.
  - On re-enable, arbitration resumes from last_grant+1.
- **Counter wrap:** TS_W=4, grant at ts_cnt=15 gives out_ts=15; the next back-to-back grant gives out_ts=0.
- **Reset mid-operation:** assert rst_n=0 while out_valid=1 and last_grant=2.
  - out_valid drops immediately.
  - After release with req_valid=4'b1111, the first grant goes to requester 0 with out_ts equal to the cycles elapsed since release.
